// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encodings, key codes and coin values for the vending controller
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHOW     = 3'd1,
    ST_COLLECT  = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_CHANGE   = 3'd4,
    ST_REFUND   = 3'd5,
    ST_SOLDOUT  = 3'd6
  } state_t;

  localparam logic [3:0] KEY_SEL1   = 4'h1;
  localparam logic [3:0] KEY_SEL2   = 4'h2;
  localparam logic [3:0] KEY_SEL3   = 4'h3;
  localparam logic [3:0] KEY_SEL4   = 4'h4;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  localparam logic [7:0] COIN_VAL_2  = 8'd2;
  localparam logic [7:0] COIN_VAL_5  = 8'd5;
  localparam logic [7:0] COIN_VAL_10 = 8'd10;

  function automatic logic is_select(input logic [3:0] code);
    return (code >= KEY_SEL1) && (code <= KEY_SEL4);
  endfunction

  // Select keys are contiguous from KEY_SEL1, so the low bits minus one give the slot.
  function automatic logic [1:0] key_slot(input logic [3:0] code);
    return code[1:0] - 2'd1;
  endfunction

endpackage

// File: rtl/vend_coin_acc.sv
// rtl/vend_coin_acc.sv - coin priority, overflow guard, amount register and reject pulse
module vend_coin_acc
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_2,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic       accept,
  input  logic       clear,
  output logic [7:0] amount,
  output logic [7:0] amount_next,
  output logic       accepted,
  output logic       coin_reject
);

  logic [7:0] coin_val;
  logic [8:0] sum;
  logic       any_coin;
  logic       multi;

  always_comb begin
    coin_val = 8'd0;
    if (coin_10)     coin_val = COIN_VAL_10;
    else if (coin_5) coin_val = COIN_VAL_5;
    else if (coin_2) coin_val = COIN_VAL_2;
    any_coin    = coin_2 | coin_5 | coin_10;
    multi       = (coin_2 & coin_5) | (coin_2 & coin_10) | (coin_5 & coin_10);
    sum         = {1'b0, amount} + {1'b0, coin_val};
    accepted    = accept & any_coin & ~sum[8];
    amount_next = accepted ? sum[7:0] : amount;
  end

  // Losers of a simultaneous drop and refused coins share a single reject pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      amount      <= 8'd0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= any_coin & (~accepted | multi);
      amount      <= clear ? 8'd0 : amount_next;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - four-product vending controller: selection, payment, dispense and change
module vend_controller
  import vend_pkg::*;
#(
  parameter logic [7:0]  PRICE0   = 8'd15,
  parameter logic [7:0]  PRICE1   = 8'd20,
  parameter logic [7:0]  PRICE2   = 8'd25,
  parameter logic [7:0]  PRICE3   = 8'd30,
  parameter logic [3:0]  INIT_QTY = 4'd5,
  parameter logic [23:0] TIMEOUT  = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       coin_2,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic       product_taken,
  output logic [7:0] display_value,
  output logic [2:0] display_mode,
  output logic       dispense,
  output logic [1:0] dispense_slot,
  output logic [7:0] change_out,
  output logic       change_valid,
  output logic       coin_reject
);

  state_t      state;
  logic [3:0]  qty [4];
  logic [23:0] timer;
  logic [7:0]  amount, amount_next, price;
  logic        coin_ok, sel_key, cancel_key, any_event, timed_out, timed_state;
  logic [1:0]  key_idx;

  always_comb begin
    case (dispense_slot)
      2'd0:    price = PRICE0;
      2'd1:    price = PRICE1;
      2'd2:    price = PRICE2;
      default: price = PRICE3;
    endcase
  end

  assign sel_key      = key_valid & is_select(key_code);
  assign cancel_key   = key_valid & (key_code == KEY_CANCEL);
  assign key_idx      = key_slot(key_code);
  assign any_event    = key_valid | coin_2 | coin_5 | coin_10;
  assign timed_state  = (state == ST_SHOW) || (state == ST_COLLECT) || (state == ST_SOLDOUT);
  assign timed_out    = !any_event && (timer >= TIMEOUT - 24'd1);
  assign display_mode = state;

  vend_coin_acc u_coin_acc (
    .clk        (clk),
    .reset      (reset),
    .coin_2     (coin_2),
    .coin_5     (coin_5),
    .coin_10    (coin_10),
    .accept     ((state == ST_SHOW) || (state == ST_COLLECT)),
    .clear      ((state == ST_CHANGE) || (state == ST_REFUND)),
    .amount     (amount),
    .amount_next(amount_next),
    .accepted   (coin_ok),
    .coin_reject(coin_reject)
  );

  always_comb begin
    case (state)
      ST_SHOW:                 display_value = price;
      ST_COLLECT, ST_DISPENSE: display_value = amount;
      ST_SOLDOUT:              display_value = 8'hFF;
      default:                 display_value = 8'd0;
    endcase
  end

  // Timed states are only entered on a key or coin, so clearing on events covers entry too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      timer         <= 24'd0;
      dispense      <= 1'b0;
      dispense_slot <= 2'd0;
      change_out    <= 8'd0;
      change_valid  <= 1'b0;
      for (int i = 0; i < 4; i++) qty[i] <= INIT_QTY;
    end else begin
      dispense     <= 1'b0;
      change_valid <= 1'b0;
      timer        <= (any_event || !timed_state) ? 24'd0 : timer + 24'd1;
      case (state)
        ST_IDLE: begin
          if (sel_key) begin
            dispense_slot <= key_idx;
            state         <= (qty[key_idx] != 4'd0) ? ST_SHOW : ST_SOLDOUT;
          end
        end
        ST_SHOW: begin
          if (coin_ok && cancel_key) begin
            state        <= ST_REFUND;
            change_out   <= amount_next;
            change_valid <= 1'b1;
          end else if (coin_ok) begin
            state <= ST_COLLECT;
          end else if (cancel_key || timed_out) begin
            state         <= ST_IDLE;
            dispense_slot <= 2'd0;
          end else if (sel_key) begin
            dispense_slot <= key_idx;
            state         <= (qty[key_idx] != 4'd0) ? ST_SHOW : ST_SOLDOUT;
          end
        end
        ST_COLLECT: begin
          if (cancel_key || timed_out) begin
            state        <= ST_REFUND;
            change_out   <= amount_next;
            change_valid <= 1'b1;
          end else if (amount >= price) begin
            state    <= ST_DISPENSE;
            dispense <= 1'b1;
            if (qty[dispense_slot] != 4'd0) qty[dispense_slot] <= qty[dispense_slot] - 4'd1;
          end
        end
        ST_DISPENSE: begin
          if (product_taken) begin
            state        <= ST_CHANGE;
            change_out   <= amount - price;
            change_valid <= 1'b1;
          end
        end
        ST_SOLDOUT: begin
          if (key_valid || timed_out) begin
            state         <= ST_IDLE;
            dispense_slot <= 2'd0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          dispense_slot <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - scoreboard bench for vend_controller
module tb_vend_controller;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       coin_2 = 1'b0, coin_5 = 1'b0, coin_10 = 1'b0;
  logic       product_taken = 1'b0;
  logic [7:0] display_value, change_out;
  logic [2:0] display_mode;
  logic       dispense, change_valid, coin_reject;
  logic [1:0] dispense_slot;

  int errors = 0;
  int checks = 0;
  int exp_change[$];
  int exp_slot[$];
  int exp_rej[$];
  int m_e;

  vend_controller #(.TIMEOUT(24'd40)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .coin_2       (coin_2),
    .coin_5       (coin_5),
    .coin_10      (coin_10),
    .product_taken(product_taken),
    .display_value(display_value),
    .display_mode (display_mode),
    .dispense     (dispense),
    .dispense_slot(dispense_slot),
    .change_out   (change_out),
    .change_valid (change_valid),
    .coin_reject  (coin_reject)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dispense) begin
      checks++;
      if (exp_slot.size() == 0) begin
        errors++;
        $display("FAIL dispense_unexpected slot=%0d", dispense_slot);
      end else begin
        m_e = exp_slot.pop_front();
        if (int'(dispense_slot) !== m_e) begin
          errors++;
          $display("FAIL dispense_slot got=%0d want=%0d", dispense_slot, m_e);
        end
      end
    end
    if (change_valid) begin
      checks++;
      if (exp_change.size() == 0) begin
        errors++;
        $display("FAIL change_unexpected out=%0d", change_out);
      end else begin
        m_e = exp_change.pop_front();
        if (int'(change_out) !== m_e) begin
          errors++;
          $display("FAIL change_out got=%0d want=%0d", change_out, m_e);
        end
      end
    end
    if (coin_reject) begin
      checks++;
      if (exp_rej.size() == 0) begin
        errors++;
        $display("FAIL coin_reject_unexpected");
      end else begin
        m_e = exp_rej.pop_front();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] c);
    key_code  = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic drop(input int v, input bit rej);
    if (rej) exp_rej.push_back(v);
    coin_2  = (v == 2);
    coin_5  = (v == 5);
    coin_10 = (v == 10);
    @(negedge clk);
    coin_2 = 1'b0; coin_5 = 1'b0; coin_10 = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, input string name);
    for (int i = 0; i < lim; i++) begin
      if (display_mode == s) break;
      @(negedge clk);
    end
    checks++;
    if (display_mode !== s) begin
      errors++;
      $display("FAIL %s state=%0d want=%0d", name, display_mode, s);
    end
  endtask

  task automatic finish_vend(input string name);
    product_taken = 1'b1;
    wait_state(ST_CHANGE, 5, {name, "_change"});
    product_taken = 1'b0;
    wait_state(ST_IDLE, 5, {name, "_idle"});
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (display_mode !== 3'd0 || display_value !== 8'd0 || dispense !== 1'b0 ||
        dispense_slot !== 2'd0 || change_out !== 8'd0 || change_valid !== 1'b0 ||
        coin_reject !== 1'b0) begin
      errors++;
      $display("FAIL %s mode=%0d disp=%0d dsp=%b slot=%0d chg=%0d cv=%b rej=%b want all zero",
               name, display_mode, display_value, dispense, dispense_slot, change_out,
               change_valid, coin_reject);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    check_reset_outputs("reset_values");
    reset = 1'b0;
    tick(1);
    drop(5, 1);
    checks++;
    if (display_mode !== ST_IDLE || display_value !== 8'd0) begin
      errors++;
      $display("FAIL idle_coin mode=%0d disp=%0d want mode=0 disp=0", display_mode, display_value);
    end
  endtask

  task automatic test_exact_pay;
    press(KEY_SEL1);
    checks++;
    if (display_mode !== ST_SHOW || display_value !== 8'd15) begin
      errors++;
      $display("FAIL show_price mode=%0d disp=%0d want mode=1 disp=15", display_mode, display_value);
    end
    exp_slot.push_back(0);
    exp_change.push_back(0);
    drop(10, 0);
    checks++;
    if (display_mode !== ST_COLLECT || display_value !== 8'd10) begin
      errors++;
      $display("FAIL collect_amount mode=%0d disp=%0d want mode=2 disp=10", display_mode, display_value);
    end
    drop(5, 0);
    wait_state(ST_DISPENSE, 5, "exact_dispense");
    finish_vend("exact");
  endtask

  task automatic test_overpay;
    press(KEY_SEL4);
    exp_slot.push_back(3);
    exp_change.push_back(10);
    repeat (4) drop(10, 0);
    checks++;
    if (display_mode !== ST_DISPENSE) begin
      errors++;
      $display("FAIL overpay_dispense state=%0d want=3", display_mode);
    end
    finish_vend("overpay");
  endtask

  task automatic test_cancel;
    press(KEY_SEL2);
    drop(5, 0);
    exp_change.push_back(5);
    press(KEY_CANCEL);
    checks++;
    if (display_mode !== ST_REFUND) begin
      errors++;
      $display("FAIL cancel_refund state=%0d want=5", display_mode);
    end
    wait_state(ST_IDLE, 5, "cancel_idle");
  endtask

  task automatic test_dual_coin;
    press(KEY_SEL3);
    drop(5, 0);
    exp_rej.push_back(2);
    coin_2 = 1'b1; coin_10 = 1'b1;
    @(negedge clk);
    coin_2 = 1'b0; coin_10 = 1'b0;
    checks++;
    if (display_mode !== ST_COLLECT || display_value !== 8'd15) begin
      errors++;
      $display("FAIL dual_coin mode=%0d amount=%0d want mode=2 amount=15", display_mode, display_value);
    end
    exp_change.push_back(15);
    press(KEY_CANCEL);
    wait_state(ST_IDLE, 5, "dual_idle");
  endtask

  task automatic test_timeout;
    press(KEY_SEL1);
    tick(30);
    checks++;
    if (display_mode !== ST_SHOW) begin
      errors++;
      $display("FAIL show_early_exit state=%0d want=1", display_mode);
    end
    wait_state(ST_IDLE, 30, "show_timeout");
    press(KEY_SEL2);
    drop(2, 0);
    exp_change.push_back(2);
    wait_state(ST_REFUND, 60, "collect_timeout");
    wait_state(ST_IDLE, 5, "collect_timeout_idle");
  endtask

  task automatic test_soldout;
    for (int n = 0; n < 4; n++) begin
      press(KEY_SEL1);
      exp_slot.push_back(0);
      exp_change.push_back(5);
      drop(10, 0);
      drop(10, 0);
      wait_state(ST_DISPENSE, 5, "buy_dispense");
      finish_vend("buy");
    end
    press(KEY_SEL1);
    checks++;
    if (display_mode !== ST_SOLDOUT || display_value !== 8'hFF) begin
      errors++;
      $display("FAIL soldout mode=%0d disp=%0d want mode=6 disp=255", display_mode, display_value);
    end
    drop(2, 1);
    checks++;
    if (display_mode !== ST_SOLDOUT) begin
      errors++;
      $display("FAIL soldout_coin state=%0d want=6", display_mode);
    end
    press(4'h7);
    checks++;
    if (display_mode !== ST_IDLE) begin
      errors++;
      $display("FAIL soldout_key state=%0d want=0", display_mode);
    end
  endtask

  task automatic test_reset_in_dispense;
    press(KEY_SEL2);
    exp_slot.push_back(1);
    drop(10, 0);
    drop(10, 0);
    wait_state(ST_DISPENSE, 5, "rst_dispense");
    tick(1);
    product_taken = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_in_dispense");
    tick(2);
    reset = 1'b0;
    product_taken = 1'b0;
    tick(3);
    check_reset_outputs("after_reset_release");
    press(KEY_SEL1);
    checks++;
    if (display_mode !== ST_SHOW) begin
      errors++;
      $display("FAIL qty_reload state=%0d want=1", display_mode);
    end
    press(KEY_CANCEL);
    wait_state(ST_IDLE, 5, "reload_idle");
  endtask

  initial begin
    test_reset();
    test_exact_pay();
    test_overpay();
    test_cancel();
    test_dual_coin();
    test_timeout();
    test_soldout();
    test_reset_in_dispense();
    tick(2);
    checks++;
    if (exp_slot.size() != 0) begin
      errors++;
      $display("FAIL missing_dispense pending=%0d want=0", exp_slot.size());
    end
    checks++;
    if (exp_change.size() != 0) begin
      errors++;
      $display("FAIL missing_change pending=%0d want=0", exp_change.size());
    end
    checks++;
    if (exp_rej.size() != 0) begin
      errors++;
      $display("FAIL missing_reject pending=%0d want=0", exp_rej.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
